// File: rtl/map_tile_mem.sv
// Playfield tile bitmap: one bit per tile, 1 = pellet present.
// Port A is a read-only display port with 1-cycle latency. Port B belongs to an
// internal controller that sweeps the map in from an external synchronous ROM,
// performs single-tile read-modify-write "eat" operations and keeps a live
// pellet count.
//
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   rd_addr / rd_data         display read row / row word (next cycle, 0 if out of range)
//   init_req                  request full reload (honoured in IDLE only)
//   init_addr / init_data     ROM row address / ROM row data (1-cycle latency)
//   init_done                 map loaded and controller idle
//   eat_valid / eat_ready     eat handshake (eat_ready is combinational)
//   eat_row / eat_col         tile to eat; column c = bit c of the row word
//   eat_hit / eat_miss        1-cycle result pulses
//   pellet_count              number of set bits in the map
module map_tile_mem #(
   parameter int unsigned ROWS   = 32,
   parameter int unsigned COLS   = 160,
   parameter int unsigned ADDR_W = $clog2(ROWS),
   parameter int unsigned COL_W  = $clog2(COLS),
   parameter int unsigned CNT_W  = $clog2(ROWS*COLS+1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COLS-1:0]   rd_data,
   input  logic              init_req,
   output logic [ADDR_W-1:0] init_addr,
   input  logic [COLS-1:0]   init_data,
   output logic              init_done,
   input  logic              eat_valid,
   input  logic [ADDR_W-1:0] eat_row,
   input  logic [COL_W-1:0]  eat_col,
   output logic              eat_ready,
   output logic              eat_hit,
   output logic              eat_miss,
   output logic [CNT_W-1:0]  pellet_count
);

   // Row counter must reach ROWS (one extra cycle to write the last ROM row).
   localparam int unsigned RC_W      = $clog2(ROWS+1);
   localparam bit          ROWS_POW2 = (ROWS == (32'd1 << ADDR_W));

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_EAT_RD = 2'd2,
      S_EAT_WR = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [RC_W-1:0]   row_cnt;
   logic [ADDR_W-1:0] eat_row_q;
   logic [COL_W-1:0]  eat_col_q;
   logic [COLS-1:0]   row_buf;
   logic [COLS-1:0]   mem [ROWS];

   logic              hit;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [COLS-1:0]   wr_data;
   logic              rd_in_range;
   logic              eat_row_in_range;

   function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] d);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < COLS; i++) begin
         n = n + CNT_W'(d[i]);
      end
      return n;
   endfunction

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_INIT;
      else       state <= state_nxt;
   end

   // Next-state logic; init_req wins over eat_valid in IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:   if (row_cnt == RC_W'(ROWS)) state_nxt = S_IDLE;
         S_IDLE: begin
            if (init_req)       state_nxt = S_INIT;
            else if (eat_valid) state_nxt = S_EAT_RD;
         end
         S_EAT_RD: state_nxt = S_EAT_WR;
         S_EAT_WR: state_nxt = S_IDLE;
         default:  state_nxt = S_INIT;
      endcase
   end

   // Output / port-B write decode
   always_comb begin
      eat_ready = 1'b0;
      hit       = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = init_data;
      case (state)
         S_INIT: begin
            // ROM data arriving now belongs to the row addressed last cycle
            wr_en   = (row_cnt != '0);
            wr_addr = ADDR_W'(row_cnt - RC_W'(1));
            wr_data = init_data;
         end
         S_IDLE:   eat_ready = !init_req;
         S_EAT_WR: begin
            hit     = (32'(eat_col_q) < COLS) && row_buf[eat_col_q];
            wr_en   = hit;
            wr_addr = eat_row_q;
            wr_data = row_buf & ~(COLS'(1) << eat_col_q);
         end
         default: ;
      endcase
   end

   assign rd_in_range      = ROWS_POW2 || (32'(rd_addr) < ROWS);
   assign eat_row_in_range = ROWS_POW2 || (32'(eat_row_q) < ROWS);

   // Controller datapath: sweep counter, eat latches, pulses, pellet count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_cnt      <= '0;
         init_addr    <= '0;
         init_done    <= 1'b0;
         eat_hit      <= 1'b0;
         eat_miss     <= 1'b0;
         pellet_count <= '0;
         eat_row_q    <= '0;
         eat_col_q    <= '0;
         row_buf      <= '0;
      end else begin
         eat_hit   <= 1'b0;
         eat_miss  <= 1'b0;
         init_done <= (state_nxt == S_IDLE);
         case (state)
            S_INIT: begin
               row_cnt <= row_cnt + RC_W'(1);
               if (row_cnt != '0) pellet_count <= pellet_count + popcount(init_data);
               if (32'(row_cnt) + 32'd1 < ROWS) init_addr <= ADDR_W'(row_cnt + RC_W'(1));
               else                             init_addr <= '0;
            end
            S_IDLE: begin
               if (init_req) begin
                  row_cnt      <= '0;
                  init_addr    <= '0;
                  pellet_count <= '0;
               end else if (eat_valid) begin
                  eat_row_q <= eat_row;
                  eat_col_q <= eat_col;
               end
            end
            S_EAT_RD: row_buf <= eat_row_in_range ? mem[eat_row_q] : '0;
            S_EAT_WR: begin
               // A hit implies a set bit, so the count is at least 1 here
               if (hit) begin
                  eat_hit      <= 1'b1;
                  pellet_count <= pellet_count - CNT_W'(1);
               end else begin
                  eat_miss <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Port A read: registered, returns pre-write data on a same-cycle collision
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rd_data <= '0;
      else       rd_data <= rd_in_range ? mem[rd_addr] : '0;
   end

   // Port B write; storage itself is not reset
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

endmodule

// File: tb/tb_map_tile_mem.sv
module tb_map_tile_mem;
   localparam int unsigned ROWS   = 32;
   localparam int unsigned COLS   = 160;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned COL_W  = 8;
   localparam int unsigned CNT_W  = 13;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [COLS-1:0]   rd_data;
   logic              init_req = 1'b0;
   logic [ADDR_W-1:0] init_addr;
   logic [COLS-1:0]   init_data = '0;
   logic              init_done;
   logic              eat_valid = 1'b0;
   logic [ADDR_W-1:0] eat_row = '0;
   logic [COL_W-1:0]  eat_col = '0;
   logic              eat_ready;
   logic              eat_hit;
   logic              eat_miss;
   logic [CNT_W-1:0]  pellet_count;

   logic [COLS-1:0] rom [ROWS];
   logic [COLS-1:0] mdl [ROWS];
   int checks = 0;
   int errors = 0;

   map_tile_mem #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clock(clock), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .init_req(init_req), .init_addr(init_addr), .init_data(init_data), .init_done(init_done),
      .eat_valid(eat_valid), .eat_row(eat_row), .eat_col(eat_col), .eat_ready(eat_ready),
      .eat_hit(eat_hit), .eat_miss(eat_miss), .pellet_count(pellet_count)
   );

   always #5 clock = ~clock;

   // External synchronous init ROM
   always @(posedge clock) init_data <= rom[init_addr];

   function automatic int model_count();
      int n = 0;
      for (int r = 0; r < ROWS; r++) n += $countones(mdl[r]);
      return n;
   endfunction

   task automatic copy_rom_to_model();
      for (int r = 0; r < ROWS; r++) mdl[r] = rom[r];
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++;
      if ({init_done, eat_ready, eat_hit, eat_miss} !== 4'b0 || pellet_count !== '0 ||
          init_addr !== '0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_values: got done=%b rdy=%b hit=%b miss=%b cnt=%0d addr=%0d rd=%0h expected all zero",
                  init_done, eat_ready, eat_hit, eat_miss, pellet_count, init_addr, rd_data);
      end
   endtask

   task automatic test_load();
      int n = 0;
      reset = 1'b0;
      while (!init_done && n < 40) begin
         if (n < ROWS) begin
            checks++;
            if (init_addr !== ADDR_W'(n)) begin
               errors++;
               $display("FAIL init_addr_seq: got %0d expected %0d", init_addr, n);
            end
         end
         @(negedge clock);
         n++;
      end
      checks++;
      if (n != ROWS + 1) begin
         errors++;
         $display("FAIL init_done_latency: got %0d cycles expected %0d", n, ROWS + 1);
      end
      copy_rom_to_model();
      checks++;
      if (int'(pellet_count) != model_count()) begin
         errors++;
         $display("FAIL load_count: got %0d expected %0d", pellet_count, model_count());
      end
      for (int r = 0; r < ROWS; r++) begin
         rd_addr = ADDR_W'(r);
         @(negedge clock);
         checks++;
         if (rd_data !== mdl[r]) begin
            errors++;
            $display("FAIL load_row%0d: got %0h expected %0h", r, rd_data, mdl[r]);
         end
      end
   endtask

   // One eat from IDLE; checks handshake, pulse timing, pre/post-write port A view, count
   task automatic run_eat(input int row, input int col, input bit poke_init);
      bit exp_hit = 1'b0;
      logic [COLS-1:0] old_row;
      old_row = mdl[row];
      if (col < int'(COLS)) exp_hit = mdl[row][col];
      eat_valid = 1'b1; eat_row = ADDR_W'(row); eat_col = COL_W'(col); rd_addr = ADDR_W'(row);
      #1;
      checks++;
      if (eat_ready !== 1'b1) begin
         errors++;
         $display("FAIL eat_ready_idle: got %b expected 1", eat_ready);
      end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         eat_valid = 1'b0;
         init_req  = poke_init && (c == 1);
         if (c == 3) begin
            if (exp_hit) mdl[row][col] = 1'b0;
            checks++;
            if (rd_data !== old_row) begin
               errors++;
               $display("FAIL rd_prewrite: got %0h expected %0h", rd_data, old_row);
            end
         end
         checks++;
         if (eat_hit !== (c == 3 && exp_hit) || eat_miss !== (c == 3 && !exp_hit)) begin
            errors++;
            $display("FAIL eat_pulse(%0d,%0d) cyc%0d: got hit=%b miss=%b expected hit=%b miss=%b",
                     row, col, c, eat_hit, eat_miss, c == 3 && exp_hit, c == 3 && !exp_hit);
         end
      end
      checks++;
      if (rd_data !== mdl[row] || int'(pellet_count) != model_count()) begin
         errors++;
         $display("FAIL eat_result(%0d,%0d): got row=%0h cnt=%0d expected row=%0h cnt=%0d",
                  row, col, rd_data, pellet_count, mdl[row], model_count());
      end
   endtask

   task automatic test_eat();
      run_eat(13, 0, 1'b1);
      rd_addr = 5'd20;
      @(negedge clock);
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL rd_row20: got %0h expected 0", rd_data);
      end
      run_eat(13, 0, 1'b0);
      run_eat(13, 200, 1'b0);
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL init_req_ignored: got init_done=%b expected 1", init_done);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 6; i++) begin
         eat_valid = (i <= 3);
         eat_row   = '0;
         eat_col   = (i < 3) ? 8'd5 : 8'd6;
         #1;
         checks++;
         if (eat_ready !== (i % 3 == 0) || eat_hit !== (i == 3 || i == 6) || eat_miss !== 1'b0) begin
            errors++;
            $display("FAIL b2b cyc%0d: got rdy=%b hit=%b miss=%b expected rdy=%b hit=%b miss=0",
                     i, eat_ready, eat_hit, eat_miss, i % 3 == 0, i == 3 || i == 6);
         end
         @(negedge clock);
      end
      mdl[0][5] = 1'b0;
      mdl[0][6] = 1'b0;
      rd_addr = '0;
      @(negedge clock);
      checks++;
      if (rd_data !== mdl[0] || int'(pellet_count) != model_count()) begin
         errors++;
         $display("FAIL b2b_result: got row0=%0h cnt=%0d expected row0=%0h cnt=%0d",
                  rd_data, pellet_count, mdl[0], model_count());
      end
   endtask

   // Request a reload from IDLE and check its exact length and outcome
   task automatic test_init_priority(input string tag);
      int n = 1;
      bit pulsed = 1'b0;
      init_req = 1'b1; eat_valid = 1'b1; eat_row = 5'd13; eat_col = '0;
      #1;
      checks++;
      if (eat_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_ready_blocked: got %b expected 0", tag, eat_ready);
      end
      @(negedge clock);
      init_req = 1'b0; eat_valid = 1'b0;
      while (!init_done && n < 50) begin
         if (eat_hit || eat_miss) pulsed = 1'b1;
         @(negedge clock);
         n++;
      end
      checks++;
      if (n != ROWS + 2 || pulsed) begin
         errors++;
         $display("FAIL %s_reload: got %0d cycles pulse=%b expected %0d cycles pulse=0", tag, n, pulsed, ROWS + 2);
      end
      copy_rom_to_model();
      checks++;
      if (int'(pellet_count) != model_count()) begin
         errors++;
         $display("FAIL %s_count: got %0d expected %0d", tag, pellet_count, model_count());
      end
      for (int k = 0; k < 4; k++) begin
         int r = (k == 0) ? 0 : (k == 1) ? 13 : $urandom_range(0, ROWS - 1);
         rd_addr = ADDR_W'(r);
         @(negedge clock);
         checks++;
         if (rd_data !== mdl[r]) begin
            errors++;
            $display("FAIL %s_row%0d: got %0h expected %0h", tag, r, rd_data, mdl[r]);
         end
      end
   endtask

   task automatic test_reset_mid_init();
      int n = 0;
      init_req = 1'b1;
      @(negedge clock);
      init_req = 1'b0;
      repeat (10) @(negedge clock);
      checks++;
      if (init_addr !== 5'd10) begin
         errors++;
         $display("FAIL mid_init_addr: got %0d expected 10", init_addr);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({init_done, eat_ready, eat_hit, eat_miss} !== 4'b0 || pellet_count !== '0 ||
          init_addr !== '0 || rd_data !== '0) begin
         errors++;
         $display("FAIL async_reset: got done=%b rdy=%b cnt=%0d addr=%0d rd=%0h expected zeros",
                  init_done, eat_ready, pellet_count, init_addr, rd_data);
      end
      @(negedge clock);
      reset = 1'b0;
      while (!init_done && n < 40) begin
         if (n < ROWS) begin
            checks++;
            if (init_addr !== ADDR_W'(n)) begin
               errors++;
               $display("FAIL resweep_addr: got %0d expected %0d", init_addr, n);
            end
         end
         @(negedge clock);
         n++;
      end
      checks++;
      if (n != ROWS + 1 || int'(pellet_count) != model_count()) begin
         errors++;
         $display("FAIL resweep: got %0d cycles cnt=%0d expected %0d cycles cnt=%0d",
                  n, pellet_count, ROWS + 1, model_count());
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < ROWS; r++)
         for (int w = 0; w < 5; w++)
            rom[r][w*32 +: 32] = (r % 7 == 3) ? 32'h0 : ($urandom & $urandom);
      test_init_priority("rand_load");
      for (int e = 0; e < 30; e++) begin
         int row = $urandom_range(0, ROWS - 1);
         int col = $urandom_range(0, 199);
         if ($urandom_range(0, 1) == 1) begin
            int s = $urandom_range(0, COLS - 1);
            for (int k = 0; k < int'(COLS); k++)
               if (mdl[row][(s + k) % COLS]) begin col = (s + k) % COLS; break; end
         end
         run_eat(row, col, 1'b0);
      end
   endtask

   initial begin
      for (int r = 0; r < ROWS; r++) rom[r] = '0;
      rom[0]  = '1;
      rom[13] = 160'h5;
      test_reset();
      test_load();
      test_eat();
      test_back_to_back();
      test_init_priority("prio");
      test_reset_mid_init();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/map_tile_mem.md
Name: map_tile_mem

Overview:
- Parametrised successor to the fixed 32x160 dual-port map RAM.
- Holds the playfield bitmap: one bit per tile, 1 = pellet present.
- Port A is a read-only display/query port with 1-cycle latency.
- Port B is owned by an internal controller that:
  - loads the map row-by-row from an external init ROM;
  - performs single-tile read-modify-write "eat" operations;
  - maintains a live pellet count for the win condition.

Parameters:
- ROWS, 32, number of map rows (words).
- COLS, 160, tiles per row (word width).
- ADDR_W, $clog2(ROWS), row address width.
- COL_W, $clog2(COLS), column index width.
- CNT_W, $clog2(ROWS*COLS+1), pellet counter width.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  ADDR_W  display read row.
- rd_data  out  COLS  row contents, valid the cycle after rd_addr is sampled.
- init_req  in  1  request a full map reload (sampled in IDLE only).
- init_addr  out  ADDR_W  row address to external init ROM.
- init_data  in  COLS  ROM row data; 1-cycle latency after init_addr.
- init_done  out  1  high when the map is loaded and the controller is idle.
- eat_valid  in  1  eat request.
- eat_row  in  ADDR_W  tile row.
- eat_col  in  COL_W  tile column; column c = bit c of the row word.
- eat_ready  out  1  request accepted this cycle when eat_valid && eat_ready.
- eat_hit  out  1  1-cycle pulse: pellet was present and has been cleared.
- eat_miss  out  1  1-cycle pulse: no pellet, or column out of range.
- pellet_count  out  CNT_W  current number of set bits in the map.

Behaviour:
- Reset (async assert):
  - state = INIT, row counter = 0;
  - init_done, eat_ready, eat_hit, eat_miss = 0;
  - pellet_count = 0, init_addr = 0, rd_data = 0.
  - On release, the INIT sweep starts automatically.
- States: INIT, IDLE, EAT_RD, EAT_WR.
- INIT sweep:
  - Cycle k (k = 0..ROWS-1): init_addr = k.
  - Cycle k+1: init_data is written to row k via port B; pellet_count += popcount(init_data).
  - pellet_count is cleared on INIT entry.
  - Sweep takes ROWS+1 cycles, then goes to IDLE.
  - init_done rises on the first IDLE cycle; it is 0 in all other states and stays 1 in IDLE.
- IDLE:
  - init_req has priority over eat_valid when both are set; init_req goes to INIT, row counter = 0.
  - eat_ready = 1 only in IDLE with no init_req.
  - On accept, eat_row/eat_col are latched and the state goes to EAT_RD.
- EAT_RD: read latched row on port B, then go to EAT_WR.
- EAT_WR:
  - If col < COLS and the bit is 1: write the row with that bit cleared, pulse eat_hit, pellet_count -= 1.
  - Otherwise: no write, pulse eat_miss.
  - Go to IDLE.
  - Hit/miss pulse is 3 cycles after the accept edge; throughput is 1 eat per 3 cycles.
- Ignored inputs:
  - init_req outside IDLE is ignored, not queued.
  - eat_valid outside IDLE is ignored (eat_ready = 0).
- Port A:
  - Always active, including during INIT; rows not yet written return their previous contents.
  - Read of a row being written on port B in the same cycle returns the pre-write data.
  - rd_addr >= ROWS returns 0.
- pellet_count never underflows: a hit requires a set bit, so the count is at least 1.
- Reset mid-INIT or mid-eat aborts the operation:
  - no write is issued after assert;
  - the sweep restarts from row 0.

Test Plan:
1. Load map: ROM gives row 0 = all ones, row 13 = 160'h5, others 0.
   - Release reset → init_addr counts 0..31.
   - init_done rises 33 cycles after release.
   - pellet_count = 162.
2. Eat (13,0): eat_ready=1 on accept, eat_hit pulse 3 cycles later, pellet_count = 161.
   - rd_addr=13 → rd_data = 160'h4 next cycle.
   - rd_addr=20 → 0.
3. Repeat eat (13,0) → eat_miss pulse, no write, count stays 161.
   - Eat (13,200) → eat_miss, row 13 unchanged.
4. Back-to-back eat_valid held high with (0,5), (0,6):
   - eat_ready only every 3rd cycle;
   - two eat_hit pulses; count 161→159;
   - row 0 bits 5,6 = 0.
5. init_req and eat_valid together in IDLE:
   - INIT is taken, eat not accepted;
   - after ROWS+1 cycles, count = 162 and rows restored.
6. Assert reset at INIT cycle 10:
   - outputs go to reset values immediately;
   - after release, full sweep from row 0, count = 162.
